// File: rtl/cr_iu_gated_clk_regfile.sv
// Clock-gated IU register file. Each entry has its own ICG, byte-strobe writes land on the next edge,
// and reads are registered with one cycle of latency plus same-cycle write forwarding. There is no backpressure.

module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic clk_en;
  logic clk_en_q;

  assign clk_en = local_en | external_en | (global_en & module_en);

  // Enable is captured in the low phase, so clk_out cannot glitch while clk_in is high.
  always_ff @(negedge clk_in) begin
    clk_en_q <= clk_en;
  end

  assign clk_out = clk_in & (clk_en_q | pad_yy_icg_scan_en);

endmodule

module cr_iu_gated_clk_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ENTRY_NUM  = 4,
  parameter int                    IDX_WIDTH  = 2,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                    forever_cpuclk,
  input  logic                    cpurst,
  input  logic                    cp0_yy_clk_en,
  input  logic                    pad_yy_gate_clk_en_b,
  input  logic                    x_randclk_reg_mod_en_w32,
  input  logic                    x_write_en,
  input  logic [IDX_WIDTH-1:0]    x_write_idx,
  input  logic [DATA_WIDTH/8-1:0] x_write_strb,
  input  logic [DATA_WIDTH-1:0]   x_write_data,
  input  logic                    x_inv_all,
  input  logic                    x_read_en,
  input  logic [IDX_WIDTH-1:0]    x_read_idx,
  output logic [DATA_WIDTH-1:0]   x_read_data,
  output logic                    x_read_vld,
  output logic [ENTRY_NUM-1:0]    x_entry_vld
);

  localparam int                 STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [IDX_WIDTH:0] ENTRY_LIM  = (IDX_WIDTH + 1)'(ENTRY_NUM);

  logic                  wr_eff;
  logic [DATA_WIDTH-1:0] strb_mask;
  logic [ENTRY_NUM-1:0]  wr_sel;
  logic [DATA_WIDTH-1:0] entry_data [ENTRY_NUM];
  logic [ENTRY_NUM-1:0]  entry_vld_q;
  logic [ENTRY_NUM-1:0]  entry_vld_nxt;
  logic [DATA_WIDTH-1:0] rd_entry;
  logic                  rd_entry_vld;
  logic                  rd_fwd;
  logic [DATA_WIDTH-1:0] rd_data_nxt;
  logic                  rd_vld_nxt;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic                  read_vld_q;

  always_comb begin
    strb_mask = '0;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      strb_mask[8*b +: 8] = {8{x_write_strb[b]}};
    end
  end

  // Out-of-range index and empty strobe both turn into a no-op, so that entry's ICG stays shut.
  assign wr_eff = x_write_en & ({1'b0, x_write_idx} < ENTRY_LIM) & (|x_write_strb);

  generate
    for (genvar i = 0; i < ENTRY_NUM; i++) begin : g_entry
      logic                  gclk;
      logic [DATA_WIDTH-1:0] q;

      assign wr_sel[i] = wr_eff & (x_write_idx == IDX_WIDTH'(i));

      gated_clk_cell u_icg (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (x_randclk_reg_mod_en_w32),
        .local_en           (wr_sel[i]),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_gate_clk_en_b),
        .clk_out            (gclk)
      );

      // The write qualifier is still needed here because global enables can open the gate without a write.
      always_ff @(posedge gclk or posedge cpurst) begin
        if (cpurst) begin
          q <= RST_VAL;
        end else if (wr_sel[i]) begin
          q <= (x_write_data & strb_mask) | (q & ~strb_mask);
        end
      end

      assign entry_data[i] = q;
    end
  endgenerate

  // An out-of-range read index matches no entry, so it reads as zero data with valid clear.
  always_comb begin
    rd_entry     = '0;
    rd_entry_vld = 1'b0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (x_read_idx == IDX_WIDTH'(i)) begin
        rd_entry     = entry_data[i];
        rd_entry_vld = entry_vld_q[i];
      end
    end
  end

  assign rd_fwd = x_read_en & wr_eff & (x_read_idx == x_write_idx);

  always_comb begin
    rd_data_nxt = rd_entry;
    rd_vld_nxt  = rd_entry_vld;
    if (rd_fwd) begin
      rd_data_nxt = (x_write_data & strb_mask) | (rd_entry & ~strb_mask);
      rd_vld_nxt  = 1'b1;
    end
  end

  // Invalidate is applied before the write's set, so a write issued with it survives alone.
  always_comb begin
    entry_vld_nxt = x_inv_all ? '0 : entry_vld_q;
    entry_vld_nxt = entry_vld_nxt | wr_sel;
  end

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      entry_vld_q <= '0;
      read_data_q <= '0;
      read_vld_q  <= 1'b0;
    end else begin
      entry_vld_q <= entry_vld_nxt;
      read_vld_q  <= x_read_en & rd_vld_nxt;
      if (x_read_en) begin
        read_data_q <= rd_data_nxt;
      end
    end
  end

  assign x_read_data = read_data_q;
  assign x_read_vld  = read_vld_q;
  assign x_entry_vld = entry_vld_q;

endmodule

// File: tb/tb_cr_iu_gated_clk_regfile.sv
// Directed bench for cr_iu_gated_clk_regfile: a default 4-entry build plus a 3-entry build
// with a non-zero reset value for range and clock-gating checks.

module tb_cr_iu_gated_clk_regfile;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        clk_en, pad_b, mod_en, we, inv, re;
  logic [1:0]  widx, ridx;
  logic [3:0]  strb;
  logic [31:0] wdata, rdata;
  logic        rvld;
  logic [3:0]  evld;

  logic        b_clk_en, b_pad_b, b_mod_en, b_we, b_inv, b_re;
  logic [1:0]  b_widx, b_ridx;
  logic [3:0]  b_strb;
  logic [31:0] b_wdata, b_rdata;
  logic        b_rvld;
  logic [2:0]  b_evld;

  int total = 0;
  int bad   = 0;
  int gc0 = 0, gc1 = 0, gc2 = 0;

  cr_iu_gated_clk_regfile dut (
    .forever_cpuclk           (clk),
    .cpurst                   (rst),
    .cp0_yy_clk_en            (clk_en),
    .pad_yy_gate_clk_en_b     (pad_b),
    .x_randclk_reg_mod_en_w32 (mod_en),
    .x_write_en               (we),
    .x_write_idx              (widx),
    .x_write_strb             (strb),
    .x_write_data             (wdata),
    .x_inv_all                (inv),
    .x_read_en                (re),
    .x_read_idx               (ridx),
    .x_read_data              (rdata),
    .x_read_vld               (rvld),
    .x_entry_vld              (evld)
  );

  cr_iu_gated_clk_regfile #(
    .DATA_WIDTH (32),
    .ENTRY_NUM  (3),
    .IDX_WIDTH  (2),
    .RST_VAL    (32'h5A5A_A5A5)
  ) dut3 (
    .forever_cpuclk           (clk),
    .cpurst                   (rst),
    .cp0_yy_clk_en            (b_clk_en),
    .pad_yy_gate_clk_en_b     (b_pad_b),
    .x_randclk_reg_mod_en_w32 (b_mod_en),
    .x_write_en               (b_we),
    .x_write_idx              (b_widx),
    .x_write_strb             (b_strb),
    .x_write_data             (b_wdata),
    .x_inv_all                (b_inv),
    .x_read_en                (b_re),
    .x_read_idx               (b_ridx),
    .x_read_data              (b_rdata),
    .x_read_vld               (b_rvld),
    .x_entry_vld              (b_evld)
  );

  always @(posedge dut3.g_entry[0].gclk) gc0++;
  always @(posedge dut3.g_entry[1].gclk) gc1++;
  always @(posedge dut3.g_entry[2].gclk) gc2++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; inv = 0; re = 0; strb = 0; widx = 0; ridx = 0; wdata = 0;
    b_we = 0; b_inv = 0; b_re = 0; b_strb = 0; b_widx = 0; b_ridx = 0; b_wdata = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    clk_en = 1; mod_en = 0; pad_b = 0;
    b_clk_en = 1; b_mod_en = 0; b_pad_b = 0;
    #22;
    total++; if (evld !== 4'b0000) begin bad++; $display("FAIL rst_evld got=%b exp=0000", evld); end
    total++; if (rvld !== 1'b0) begin bad++; $display("FAIL rst_rvld got=%b exp=0", rvld); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=00000000", rdata); end
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      re = 1; ridx = 2'(i);
      cyc();
      total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_read%0d_data got=%h exp=00000000", i, rdata); end
      total++; if (rvld !== 1'b0) begin bad++; $display("FAIL rst_read%0d_vld got=%b exp=0", i, rvld); end
    end
    idle();
  endtask

  task automatic test_strobe_write();
    we = 1; widx = 2; strb = 4'hF; wdata = 32'hDEAD_BEEF;
    cyc();
    strb = 4'b0101; wdata = 32'h1122_3344;
    cyc();
    idle(); re = 1; ridx = 2;
    cyc();
    total++; if (rdata !== 32'hDE22_BE44) begin bad++; $display("FAIL strb_rdata got=%h exp=DE22BE44", rdata); end
    total++; if (rvld !== 1'b1) begin bad++; $display("FAIL strb_rvld got=%b exp=1", rvld); end
    total++; if (evld !== 4'b0100) begin bad++; $display("FAIL strb_evld got=%b exp=0100", evld); end
    idle();
    cyc();
    total++; if (rdata !== 32'hDE22_BE44) begin bad++; $display("FAIL hold_rdata got=%h exp=DE22BE44", rdata); end
    total++; if (rvld !== 1'b0) begin bad++; $display("FAIL hold_rvld got=%b exp=0", rvld); end
  endtask

  task automatic test_forward();
    we = 1; widx = 1; strb = 4'hF; wdata = 32'hCAFE_F00D; re = 1; ridx = 1;
    cyc();
    total++; if (rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL fwd_full_rdata got=%h exp=CAFEF00D", rdata); end
    total++; if (rvld !== 1'b1) begin bad++; $display("FAIL fwd_full_rvld got=%b exp=1", rvld); end
    we = 1; widx = 2; strb = 4'b1000; wdata = 32'hAA00_0000; re = 1; ridx = 2;
    cyc();
    total++; if (rdata !== 32'hAA22_BE44) begin bad++; $display("FAIL fwd_part_rdata got=%h exp=AA22BE44", rdata); end
    total++; if (evld !== 4'b0110) begin bad++; $display("FAIL fwd_evld got=%b exp=0110", evld); end
    idle();
  endtask

  task automatic test_inv_all();
    we = 1; widx = 0; strb = 4'hF; wdata = 32'h0101_0101;
    cyc();
    widx = 3; wdata = 32'h3333_3333;
    cyc();
    total++; if (evld !== 4'b1111) begin bad++; $display("FAIL inv_pre_evld got=%b exp=1111", evld); end
    inv = 1; widx = 0; strb = 4'b0001; wdata = 32'h0000_00A0; re = 1; ridx = 0;
    cyc();
    total++; if (evld !== 4'b0001) begin bad++; $display("FAIL inv_evld got=%b exp=0001", evld); end
    total++; if (rvld !== 1'b1) begin bad++; $display("FAIL inv_fwd_rvld got=%b exp=1", rvld); end
    total++; if (rdata !== 32'h0101_01A0) begin bad++; $display("FAIL inv_fwd_rdata got=%h exp=010101A0", rdata); end
    idle(); re = 1; ridx = 3;
    cyc();
    total++; if (rvld !== 1'b0) begin bad++; $display("FAIL inv_rd3_vld got=%b exp=0", rvld); end
    total++; if (rdata !== 32'h3333_3333) begin bad++; $display("FAIL inv_rd3_data got=%h exp=33333333", rdata); end
    ridx = 2;
    cyc();
    total++; if (rdata !== 32'hAA22_BE44) begin bad++; $display("FAIL inv_rd2_data got=%h exp=AA22BE44", rdata); end
    idle();
  endtask

  task automatic test_ignored_writes();
    int s0, s1, s2;
    b_re = 1; b_ridx = 0;
    cyc();
    total++; if (b_rdata !== 32'h5A5A_A5A5) begin bad++; $display("FAIL b_rstval got=%h exp=5A5AA5A5", b_rdata); end
    total++; if (b_rvld !== 1'b0) begin bad++; $display("FAIL b_rstval_vld got=%b exp=0", b_rvld); end
    idle(); b_we = 1; b_widx = 1; b_strb = 4'hF; b_wdata = 32'h1234_5678;
    cyc();
    total++; if (b_evld !== 3'b010) begin bad++; $display("FAIL b_wr1_evld got=%b exp=010", b_evld); end
    b_clk_en = 0; b_mod_en = 0; b_pad_b = 0;
    s0 = gc0; s1 = gc1; s2 = gc2;
    b_strb = 4'h0; b_wdata = 32'hFFFF_FFFF;
    cyc();
    b_widx = 3; b_strb = 4'hF;
    cyc();
    idle();
    cyc();
    total++; if (gc0 - s0 !== 0) begin bad++; $display("FAIL b_gclk0_quiet got=%0d exp=0", gc0 - s0); end
    total++; if (gc1 - s1 !== 0) begin bad++; $display("FAIL b_gclk1_quiet got=%0d exp=0", gc1 - s1); end
    total++; if (gc2 - s2 !== 0) begin bad++; $display("FAIL b_gclk2_quiet got=%0d exp=0", gc2 - s2); end
    total++; if (b_evld !== 3'b010) begin bad++; $display("FAIL b_ign_evld got=%b exp=010", b_evld); end
    b_re = 1; b_ridx = 1;
    cyc();
    total++; if (b_rdata !== 32'h1234_5678) begin bad++; $display("FAIL b_rd1_data got=%h exp=12345678", b_rdata); end
    total++; if (b_rvld !== 1'b1) begin bad++; $display("FAIL b_rd1_vld got=%b exp=1", b_rvld); end
    b_ridx = 3;
    cyc();
    total++; if (b_rdata !== 32'h0) begin bad++; $display("FAIL b_oor_data got=%h exp=00000000", b_rdata); end
    total++; if (b_rvld !== 1'b0) begin bad++; $display("FAIL b_oor_vld got=%b exp=0", b_rvld); end
    idle();
    s0 = gc0; s2 = gc2;
    b_we = 1; b_widx = 2; b_strb = 4'b0001; b_wdata = 32'h0000_00EE;
    cyc();
    idle();
    cyc();
    total++; if (gc2 - s2 !== 1) begin bad++; $display("FAIL b_gclk2_wr got=%0d exp=1", gc2 - s2); end
    total++; if (gc0 - s0 !== 0) begin bad++; $display("FAIL b_gclk0_wr got=%0d exp=0", gc0 - s0); end
    b_re = 1; b_ridx = 2;
    cyc();
    total++; if (b_rdata !== 32'h5A5A_A5EE) begin bad++; $display("FAIL b_rd2_data got=%h exp=5A5AA5EE", b_rdata); end
    total++; if (b_evld !== 3'b110) begin bad++; $display("FAIL b_rd2_evld got=%b exp=110", b_evld); end
    idle();
    b_clk_en = 1;
  endtask

  task automatic test_async_reset();
    re = 1; ridx = 3;
    cyc();
    we = 1; widx = 1; strb = 4'hF; wdata = 32'hFFFF_0000; re = 1; ridx = 1;
    #3;
    rst = 1;
    #1;
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL arst_rdata got=%h exp=00000000", rdata); end
    total++; if (rvld !== 1'b0) begin bad++; $display("FAIL arst_rvld got=%b exp=0", rvld); end
    total++; if (evld !== 4'b0000) begin bad++; $display("FAIL arst_evld got=%b exp=0000", evld); end
    cyc();
    rst = 0; idle();
    re = 1; ridx = 1;
    cyc();
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL arst_entry1 got=%h exp=00000000", rdata); end
    total++; if (rvld !== 1'b0) begin bad++; $display("FAIL arst_entry1_vld got=%b exp=0", rvld); end
    total++; if (evld !== 4'b0000) begin bad++; $display("FAIL arst_post_evld got=%b exp=0000", evld); end
    ridx = 2;
    cyc();
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL arst_entry2 got=%h exp=00000000", rdata); end
    idle();
  endtask

  initial begin
    test_reset();
    test_strobe_write();
    test_forward();
    test_inv_all();
    test_ignored_writes();
    test_async_reset();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
